seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring divider; the inverse operation of the arithmetic unit's multiply path.
- Accepts a 2*WIDTH dividend, the same width as the arithmetic unit result, and a WIDTH divisor.
- Returns a 2*WIDTH quotient and a WIDTH remainder.
- Valid/ready handshake on both sides; sits downstream of the arithmetic unit in the datapath.

Parameters:
WIDTH, 8, divisor/remainder width; dividend/quotient width is 2*WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  divider can accept operands
dividend  input  2*WIDTH  unsigned dividend
divisor  input  WIDTH  unsigned divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  2*WIDTH  dividend / divisor
remainder  output  WIDTH  dividend % divisor
div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance edge is when in_valid&&in_ready.
  - At acceptance, latch dividend and divisor, clear the partial remainder (WIDTH+1 bits), and load counter=2*WIDTH.
  - Divisor==0: go to DONE, quotient=all ones, remainder=dividend[WIDTH-1:0], div_by_zero=1.
  - Otherwise: go to BUSY, div_by_zero=0.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each edge processes one quotient bit, MSB first:
    - shift {partial remainder, dividend MSB} left;
    - trial-subtract the divisor;
    - if the result is non-negative, keep it and set the quotient bit to 1; else restore and set the bit to 0.
  - Counter decrements each edge; after the 2*WIDTH-th BUSY edge, go to DONE.
- DONE:
  - out_valid=1.
  - quotient, remainder and div_by_zero stay stable until out_valid&&out_ready.
  - On out_valid&&out_ready, go to IDLE; out_valid=0 next cycle; outputs hold their last values.
- Latency, non-zero divisor: out_valid rises 2*WIDTH+1 edges after the acceptance edge (16 BUSY edges plus the entry edge, 17 total for WIDTH=8).
- Latency, zero divisor: out_valid is high the cycle after acceptance.
- Throughput: one operation in flight. A new acceptance is possible the cycle after the result handshake; there is no same-cycle accept-on-drain.
- in_ready is a pure function of state (IDLE only). No combinational path from in_valid or out_ready to any output.
- Backpressure: out_ready held low keeps DONE indefinitely; results are never dropped or overwritten.
- Reset asserted in any state returns to IDLE immediately and the in-flight operation is discarded.
- Boundaries:
  - dividend<divisor gives q=0, r=dividend.
  - dividend=0 gives q=0, r=0.
  - divisor=1 gives q=dividend, r=0.
  - Max operands: exact result, no overflow.

Optional Feature:
SEQ_DIVIDER_SIGNED_EN
- Defined:
  - dividend and divisor are two's complement.
  - Magnitudes are divided as above, then signs are fixed up in one extra cycle (state FIXUP between BUSY and DONE). Latency becomes 2*WIDTH+2.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative dividend / -1 wraps: quotient=100..0, remainder=0.
  - Divide by zero: quotient=all ones, remainder=dividend[WIDTH-1:0], div_by_zero=1; sign fix-up is skipped.
- Undefined: unsigned only, no FIXUP state, latency 2*WIDTH+1.

Test Plan:
- Basic divide, unsigned build:
  - Stimulus: dividend=15, divisor=1, out_ready=1.
  - Response: q=15, r=0, div_by_zero=0; out_valid exactly 17 edges after acceptance; in_ready low throughout.
- General and max-value cases:
  - Stimulus: dividend=1000, divisor=7; then dividend=65535, divisor=255.
  - Response: q=142, r=6; then q=257, r=0.
- Divide by zero:
  - Stimulus: dividend=0x1234, divisor=0.
  - Response: out_valid the next cycle; q=0xFFFF, r=0x34, div_by_zero=1.
- Backpressure and busy-input rejection:
  - Stimulus: dividend=100, divisor=9, out_ready=0 for 5 cycles after out_valid rises; in_valid=1 with new operands during BUSY.
  - Response: q=11, r=1 held stable while stalled; the BUSY operands are not accepted; in_ready returns 1 only after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 on the 8th BUSY cycle, release, then issue dividend=50, divisor=5.
  - Response: outputs reset immediately; the next result is q=10, r=0 with normal latency.
- Signed build (SEQ_DIVIDER_SIGNED_EN):
  - Stimulus: dividend=-7 (0xFFF9), divisor=2; then 0x8000 / 0xFF.
  - Response: q=-3 (0xFFFD), r=-1 (0xFF), 18-edge latency; then q=0x8000, r=0.

Source files
------------

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// slave is the divider side, master the producer/consumer side.
interface seq_divider_if #(
  parameter int WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands (adds FIXUP).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH:0]    prem_q, prem_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH+1:0]  shifted;
  logic [WIDTH+1:0]  trial;
  logic              qbit;
  logic [WIDTH:0]    prem_nx;
  logic [DW-1:0]     dvd_nx;
  logic [DW-1:0]     dvd_in;
  logic [WIDTH-1:0]  dvs_in;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              dvd_neg, dvs_neg;

  assign dvd_neg = bus.dividend[DW-1];
  assign dvs_neg = bus.divisor[WIDTH-1];
  assign dvd_in  = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_in  = dvs_neg ? -bus.divisor : bus.divisor;
`else
  assign dvd_in  = bus.dividend;
  assign dvs_in  = bus.divisor;
`endif

  // One restoring step: shift in next dividend bit, trial-subtract.
  always_comb begin
    shifted = {prem_q, dvd_q[DW-1]};
    trial   = shifted - {2'b00, dvs_q};
    qbit    = ~trial[WIDTH+1];
    prem_nx = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
    dvd_nx  = {dvd_q[DW-2:0], qbit};
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d  = dvd_in;
          dvs_d  = dvs_in;
          prem_d = '0;
          cnt_d  = CW'(DW);
`ifdef SEQ_DIVIDER_SIGNED_EN
          negq_d = dvd_neg ^ dvs_neg;
          negr_d = dvd_neg;
`endif
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend[WIDTH-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
            dbz_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        dvd_d  = dvd_nx;
        prem_d = prem_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = DONE;
          quo_d   = dvd_nx;
          rem_d   = prem_nx[WIDTH-1:0];
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIXUP: begin
        state_d = DONE;
        quo_d   = negq_q ? -dvd_q : dvd_q;
        rem_d   = negr_q ? -prem_q[WIDTH-1:0]
                         : prem_q[WIDTH-1:0];
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus
// backpressure and mid-operation reset sequences.
module tb_seq_divider;
  localparam int W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int L = 2 * W + 2;
`else
  localparam int L = 2 * W + 1;
`endif

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Issue one operation; returns edges from acceptance to out_valid.
  task automatic run_op(input logic [2*W-1:0] a,
                        input logic [W-1:0] b,
                        output int lat,
                        output logic rdy_seen);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    vec_t tbl[$];
    int   lat;
    logic rdy;
    logic bad;

`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl.push_back('{16'hFFF9, 8'h02, 16'hFFFD, 8'hFF, 1'b0});
    tbl.push_back('{16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0});
    tbl.push_back('{16'h0007, 8'hFE, 16'hFFFD, 8'h01, 1'b0});
    tbl.push_back('{16'hFFF9, 8'hFE, 16'h0003, 8'hFF, 1'b0});
    tbl.push_back('{16'd100,  8'd7,  16'd14,   8'd2,  1'b0});
    tbl.push_back('{16'hFF9C, 8'd10, 16'hFFF6, 8'h00, 1'b0});
    tbl.push_back('{16'h8000, 8'h01, 16'h8000, 8'h00, 1'b0});
    tbl.push_back('{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1});
    tbl.push_back('{16'd0,    8'd3,  16'd0,    8'd0,  1'b0});
`else
    tbl.push_back('{16'd15,    8'd1,   16'd15,    8'd0,   1'b0});
    tbl.push_back('{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0});
    tbl.push_back('{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0});
    tbl.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1});
    tbl.push_back('{16'd5,     8'd9,   16'd0,     8'd5,   1'b0});
    tbl.push_back('{16'd0,     8'd3,   16'd0,     8'd0,   1'b0});
    tbl.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0});
    tbl.push_back('{16'd65535, 8'd254, 16'd258,   8'd3,   1'b0});
    tbl.push_back('{16'd300,   8'd255, 16'd1,     8'd45,  1'b0});
    tbl.push_back('{16'hABCD,  8'h10,  16'h0ABC,  8'h0D,  1'b0});
`endif

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst quotient", 32'(bus.quotient), 32'd0);
    check("rst remainder", 32'(bus.remainder), 32'd0);
    check("rst dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].dvd, tbl[i].dvs, lat, rdy);
      check($sformatf("v%0d q", i), 32'(bus.quotient), 32'(tbl[i].q));
      check($sformatf("v%0d r", i), 32'(bus.remainder), 32'(tbl[i].r));
      check($sformatf("v%0d dbz", i), 32'(bus.div_by_zero),
            32'(tbl[i].dbz));
      check($sformatf("v%0d latency", i), 32'(lat),
            tbl[i].dbz ? 32'd1 : 32'(L));
      check($sformatf("v%0d ready in busy", i), 32'(rdy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d drain", i),
            {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    end

    // Backpressure with new operands offered while busy.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 8'd9;
    @(posedge clk);
    #1;
    bus.dividend = 16'd200;
    bus.divisor  = 8'd3;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("bp latency", 32'(lat), 32'(L));
    check("bp q", 32'(bus.quotient), 32'd11);
    check("bp r", 32'(bus.remainder), 32'd1);
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.in_ready ||
          bus.quotient != 16'd11 || bus.remainder != 8'd1)
        bad = 1'b1;
    end
    check("bp stall stable", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release",
          {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    check("bp hold q", 32'(bus.quotient), 32'd11);

    // Reset on the 8th busy cycle discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
    check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid rst q", 32'(bus.quotient), 32'd0);
    check("mid rst r", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd50, 8'd5, lat, rdy);
    check("post rst q", 32'(bus.quotient), 32'd10);
    check("post rst r", 32'(bus.remainder), 32'd0);
    check("post rst latency", 32'(lat), 32'(L));

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
